// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequencer driving a registered 1-bit full adder LSB-first
//
// Optional feature macro: SERIAL_ADD_SUB_EN (adds 'sub' input for A - B).
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   start       add request, sampled only while idle
//   op_a, op_b  WIDTH-bit operands, captured with start
//   sub         (SERIAL_ADD_SUB_EN only) 1 = compute op_a - op_b
//   busy        high from the cycle after acceptance through the done cycle
//   done        one-cycle completion pulse
//   result      WIDTH-bit sum, held until the next completion
//   carry_out   final carry (no-borrow when subtracting), held with result
//   dp_reset_n  datapath reset, ~reset
//   ip1, ip2    operand bits to the datapath, zero outside DRIVE
//   c_in        carry to the datapath, zero outside DRIVE
//   sum_i       datapath registered sum
//   carry_i     datapath registered carry

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             dp_reset_n,
  output logic             ip1,
  output logic             ip2,
  output logic             c_in,
  input  logic             sum_i,
  input  logic             carry_i
);

  // Keep the bit index at least one bit wide so WIDTH=1 still elaborates.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             cr;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] b_load;
  logic             cr_load;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert B and seed the carry with 1.
  assign b_load  = sub ? ~op_b : op_b;
  assign cr_load = sub;
`else
  assign b_load  = op_b;
  assign cr_load = 1'b0;
`endif

  // New sum bit enters at the MSB; after WIDTH captures bit 0 sits at the LSB.
  // Written as a shifted concatenation so WIDTH=1 needs no special case.
  assign res_next = WIDTH'({sum_i, res_sh} >> 1);

  assign dp_reset_n = ~reset;
  assign ip1        = (state == DRIVE) & a_sh[0];
  assign ip2        = (state == DRIVE) & b_sh[0];
  assign c_in       = (state == DRIVE) & cr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cr        <= 1'b0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= op_a;
            b_sh   <= b_load;
            cr     <= cr_load;
            idx    <= '0;
            res_sh <= '0;
            busy   <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          res_sh <= res_next;
          cr     <= carry_i;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Publish straight from the final capture so result is valid in DONE.
            result    <= res_next;
            carry_out <= carry_i;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= DRIVE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         sub_r = 1'b0;
  logic         busy, done, carry_out, dp_reset_n, ip1, ip2, c_in;
  logic [W-1:0] result;
  logic         sum_i, carry_i;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub        (sub_r),
`endif
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .dp_reset_n (dp_reset_n),
    .ip1        (ip1),
    .ip2        (ip2),
    .c_in       (c_in),
    .sum_i      (sum_i),
    .carry_i    (carry_i)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Registered 1-bit full adder datapath.
  logic dp_s = 1'b0, dp_c = 1'b0;
  always @(posedge clock) begin
    if (!dp_reset_n) {dp_c, dp_s} <= 2'b00;
    else             {dp_c, dp_s} <= 2'(ip1) + 2'(ip2) + 2'(c_in);
  end
  assign sum_i   = dp_s;
  assign carry_i = dp_c;

  // Transaction-level reference: a cycle count since acceptance plus the
  // arithmetic answer; the held outputs change only on completion.
  bit           m_active = 0;
  int           m_cyc    = 0;
  logic [W-1:0] m_a, m_bx;
  logic         m_cin0;
  logic [W-1:0] m_res = '0;
  logic         m_co  = 1'b0;
  logic         cap_carry = 1'b0;

  always @(posedge clock) begin
    longint unsigned s;
    if (reset) begin
      m_active = 0;
      m_res    = '0;
      m_co     = 1'b0;
    end else if (m_active) begin
      if (m_cyc == 2*W + 1) begin
        m_active = 0;
      end else begin
        m_cyc++;
        if (m_cyc == 2*W + 1) begin
          s     = longint'(m_a) + longint'(m_bx) + longint'(m_cin0);
          m_res = s[W-1:0];
          m_co  = s[W];
        end
      end
    end else if (start) begin
      m_active = 1;
      m_cyc    = 1;
      m_a      = op_a;
      m_cin0   = SUB_EN ? sub_r : 1'b0;
      m_bx     = m_cin0 ? ~op_b : op_b;
    end
  end

  // Every-cycle output check against the reference.
  always @(negedge clock) begin
    int i;
    longint unsigned mask, cin_i;
    bit drive;
    drive = m_active && (m_cyc % 2 == 1) && (m_cyc < 2*W + 1);
    chk("busy", busy, m_active);
    chk("done", done, m_active && m_cyc == 2*W + 1);
    chk("result_hold", result, m_res);
    chk("carry_hold", carry_out, m_co);
    chk("dp_reset_n", dp_reset_n, !reset);
    if (drive) begin
      i     = (m_cyc - 1) / 2;
      mask  = (64'd1 << i) - 1;
      cin_i = (((longint'(m_a) & mask) + (longint'(m_bx) & mask) + m_cin0) >> i) & 1;
      chk("ip1", ip1, m_a[i]);
      chk("ip2", ip2, m_bx[i]);
      chk("c_in", c_in, cin_i);
      if (i > 0) chk("c_in_vs_dp", c_in, cap_carry);
    end else begin
      chk("ip_idle", {ip1, ip2, c_in}, 3'b000);
    end
    if (m_active && m_cyc % 2 == 0 && m_cyc > 0) cap_carry = carry_i;
  end

  // Apply one operation; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input bit noise, input logic [W-1:0] er, input bit eco);
    int n;
    n = 0;
    while (m_active && n < 100) begin
      @(negedge clock);
      n++;
    end
    op_a = a; op_b = b; sub_r = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (noise) begin
        start = $urandom_range(0, 1);
        op_a  = $urandom;
        op_b  = $urandom;
        sub_r = $urandom_range(0, 1);
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    chk("latency", n, 2*W + 1);
    chk("result", result, er);
    chk("carry_out", carry_out, eco);
    if (noise) begin
      // A start during the DONE cycle must be ignored.
      start = 1'b1; op_a = 8'h11; op_b = 8'h22; sub_r = 1'b0;
      @(negedge clock);
      start = 1'b0;
      chk("done_cycle_start_ignored", busy, 1'b0);
      chk("result_after_ignore", result, er);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W:0]   s9;
    bit           sb;
    int           n;

    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 1'b0);
    reset = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFE, 1'b1);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);
    // Immediately following done: accepted in the IDLE cycle right after.
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset at cycle 6 of 0xAA+0x55 aborts with no done pulse.
    @(negedge clock);
    op_a = 8'hAA; op_b = 8'h55; sub_r = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry_out, 1'b0);
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    run_op(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1);
    run_op(8'h05, 8'h07, 1'b0, 1'b0, 8'h0C, 1'b0);
`endif

    repeat (24) begin
      a  = $urandom;
      b  = $urandom;
      sb = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      s9 = sb ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
      run_op(a, b, sb, 1'($urandom_range(0, 1)), s9[W-1:0], s9[W]);
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
